// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl_if
// Description : Program launch handshake between the host and branch_ctrl.
//               The host raises req_valid with req_addr; the block answers
//               with req_ready while idle and pulses done when the program
//               has finished.
// Signals     : req_valid  host -> block  launch request
//               req_addr   host -> block  program start address
//               req_ready  block -> host  launch request can be accepted
//               done       block -> host  one-cycle completion pulse
// Revision    : 1.0  initial release
// ============================================================================
interface branch_ctrl_if #(
  parameter int INSTR_WIDTH = 9
);
  logic                   req_valid;
  logic [INSTR_WIDTH-1:0] req_addr;
  logic                   req_ready;
  logic                   done;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : Control-side driver of the program counter. Owns the program
//               launch handshake, holds the compare flags (Z, N), evaluates
//               branch conditions and detects halt. branch/taken/target/start
//               are combinational so prog_counter acts on the same edge.
// Ports       : clk, rst_n            clock, async active-low reset
//               host (slave modport)  req_valid/req_addr/req_ready/done
//               pc_in                 current PC from prog_counter
//               is_branch, br_cond, br_offset   decoded branch
//               cmp_en, cmp_a, cmp_b  decoded compare (signed operands)
//               is_halt               decoded halt
//               start, start_addr     prog_counter load request
//               branch, taken, target prog_counter branch control
//               instr_cnt             instructions executed in current/last run
//               timeout               run was ended by the watchdog
// Options     : BRANCH_CTRL_WDT_EN  enables the RUN-cycle watchdog; without
//               it timeout is tied low and RUN lasts until halt.
// Revision    : 1.0  initial release
// ============================================================================
module branch_ctrl #(
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int WDT_CYCLES  = 1023
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  branch_ctrl_if.slave                host,
  input  wire logic [INSTR_WIDTH-1:0] pc_in,
  input  wire logic                   is_branch,
  input  wire logic [1:0]             br_cond,
  input  wire logic [REG_WIDTH-1:0]   br_offset,
  input  wire logic                   cmp_en,
  input  wire logic [REG_WIDTH-1:0]   cmp_a,
  input  wire logic [REG_WIDTH-1:0]   cmp_b,
  input  wire logic                   is_halt,
  output logic                        start,
  output logic [INSTR_WIDTH-1:0]      start_addr,
  output logic                        branch,
  output logic                        taken,
  output logic [REG_WIDTH-1:0]        target,
  output logic [CNT_WIDTH-1:0]        instr_cnt,
  output logic                        timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The watchdog limit must leave room for at least one ordinary RUN cycle.
  if (WDT_CYCLES < 2) begin : g_bad_wdt
    $error("branch_ctrl: WDT_CYCLES must be at least 2");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [INSTR_WIDTH-1:0] r_addr_q;
  logic                   r_z;
  logic                   r_n;
  logic                   w_launch;
  logic                   w_cond_true;
  logic                   w_wdt_hit;
  logic                   w_in_run;

  assign w_in_run = (r_state == S_RUN);
  assign target   = br_offset;

  // Conditions read the registered flags, so a compare in the same cycle as
  // a branch only affects later branches.
  always_comb begin
    w_cond_true = 1'b1;
    case (br_cond)
      2'b00:   w_cond_true = 1'b1;
      2'b01:   w_cond_true = r_z;
      2'b10:   w_cond_true = ~r_z;
      default: w_cond_true = r_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    start          = 1'b1;
    start_addr     = r_addr_q;
    branch         = 1'b0;
    taken          = 1'b0;
    host.req_ready = 1'b0;
    host.done      = 1'b0;
    w_launch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        host.req_ready = 1'b1;
        if (host.req_valid) begin
          w_launch = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        start  = 1'b0;
        branch = is_branch & ~is_halt;
        taken  = is_branch & ~is_halt & w_cond_true;
        // Halt and watchdog both freeze the PC on the current instruction.
        if (is_halt || w_wdt_hit) begin
          start      = 1'b1;
          start_addr = pc_in;
          w_next     = S_DONE;
        end
      end
      default: begin
        host.done = 1'b1;
        w_next    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q  <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      instr_cnt <= '0;
    end else if (w_launch) begin
      r_addr_q  <= host.req_addr;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      instr_cnt <= '0;
    end else if (w_in_run) begin
      if (is_halt || w_wdt_hit) r_addr_q <= pc_in;
      if (cmp_en) begin
        r_z <= (cmp_a == cmp_b);
        r_n <= ($signed(cmp_a) < $signed(cmp_b));
      end
      if (instr_cnt != {CNT_WIDTH{1'b1}}) instr_cnt <= instr_cnt + 1'b1;
    end
  end

`ifdef BRANCH_CTRL_WDT_EN
  localparam int c_WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYCLES - 1);

  // Counts RUN cycles already completed; the cycle that finds WDT_CYCLES-1
  // here is the last permitted one, so RUN lasts exactly WDT_CYCLES cycles.
  logic [c_WDT_W-1:0] r_wdt_cnt;
  logic               r_timeout;

  assign w_wdt_hit = w_in_run & (r_wdt_cnt == c_WDT_LAST);
  assign timeout   = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_launch) begin
      r_wdt_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_in_run) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
      if (w_wdt_hit && !is_halt) r_timeout <= 1'b1;
    end
  end
`else
  assign w_wdt_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Directed self-checking bench for branch_ctrl. Decode inputs
//               and pc_in are driven directly; each scenario task checks the
//               combinational outputs just after the falling edge and the
//               registered state one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] pc_in;
  logic       is_branch;
  logic [1:0] br_cond;
  logic [7:0] br_offset;
  logic       cmp_en;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic       is_halt;
  logic       start;
  logic [8:0] start_addr;
  logic       branch;
  logic       taken;
  logic [7:0] target;
  logic [15:0] instr_cnt;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  branch_ctrl_if #(.INSTR_WIDTH(9)) host ();

  branch_ctrl #(
    .INSTR_WIDTH(9),
    .REG_WIDTH  (8),
    .CNT_WIDTH  (16),
    .WDT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host),
    .pc_in     (pc_in),
    .is_branch (is_branch),
    .br_cond   (br_cond),
    .br_offset (br_offset),
    .cmp_en    (cmp_en),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .is_halt   (is_halt),
    .start     (start),
    .start_addr(start_addr),
    .branch    (branch),
    .taken     (taken),
    .target    (target),
    .instr_cnt (instr_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    is_branch = 1'b0; br_cond = 2'b00; br_offset = 8'h00;
    cmp_en = 1'b0; cmp_a = 8'h00; cmp_b = 8'h00; is_halt = 1'b0;
    host.req_valid = 1'b0;
  endtask

  // Issue a launch from IDLE; returns at the falling edge inside LOAD.
  task automatic launch(input logic [8:0] addr);
    host.req_valid = 1'b1;
    host.req_addr  = addr;
    tick();
    host.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    host.req_addr = 9'h000;
    pc_in = 9'h000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL reset_start got=%b exp=1", start); end
    checks++; if (start_addr !== 9'h000) begin errors++; $display("FAIL reset_start_addr got=%h exp=000", start_addr); end
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", host.req_ready); end
    checks++; if ({branch, taken, host.done, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_zero_outs got=%b exp=0000", {branch, taken, host.done, timeout}); end
    checks++; if (instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_instr_cnt got=%0d exp=0", instr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_launch();
    host.req_valid = 1'b1;
    host.req_addr  = 9'h040;
    #1;
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got=%b exp=1", host.req_ready); end
    tick();
    host.req_valid = 1'b0;
    #1;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready got=%b exp=0", host.req_ready); end
    checks++; if (start !== 1'b1 || start_addr !== 9'h040) begin errors++; $display("FAIL load_start got=%b/%h exp=1/040", start, start_addr); end
    tick();
  endtask

  // RUN cycles 1..9: compare/branch behaviour.
  task automatic test_branches();
    // cycle 1: compare 5,5 -> Z=1
    pc_in = 9'h040; cmp_en = 1'b1; cmp_a = 8'd5; cmp_b = 8'd5;
    #1;
    checks++; if (start !== 1'b0 || host.req_ready !== 1'b0) begin errors++; $display("FAIL run_start got=%b/%b exp=0/0", start, host.req_ready); end
    checks++; if (instr_cnt !== 16'd0) begin errors++; $display("FAIL run_cnt_first got=%0d exp=0", instr_cnt); end
    tick(); clr_inputs();
    // cycle 2: EQ branch, offset -3
    pc_in = 9'h045; is_branch = 1'b1; br_cond = 2'b01; br_offset = 8'hFD;
    #1;
    checks++; if ({branch, taken} !== 2'b11 || target !== 8'hFD) begin errors++; $display("FAIL eq_branch got=%b%b/%h exp=11/fd", branch, taken, target); end
    tick(); clr_inputs();
    // cycle 3: compare -2,1 -> Z=0 N=1
    pc_in = 9'h042; cmp_en = 1'b1; cmp_a = 8'hFE; cmp_b = 8'h01;
    tick(); clr_inputs();
    // cycle 4: NE and LT both true
    pc_in = 9'h050; is_branch = 1'b1; br_cond = 2'b10; br_offset = 8'h02;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL ne_taken got=%b exp=1", taken); end
    br_cond = 2'b11;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL lt_neg_taken got=%b exp=1", taken); end
    tick(); clr_inputs();
    // cycle 5: compare 3,1 -> Z=0 N=0
    pc_in = 9'h051; cmp_en = 1'b1; cmp_a = 8'd3; cmp_b = 8'd1;
    tick(); clr_inputs();
    // cycle 6: LT false, always true
    pc_in = 9'h050; is_branch = 1'b1; br_cond = 2'b11; br_offset = 8'h02;
    #1;
    checks++; if ({branch, taken} !== 2'b10) begin errors++; $display("FAIL lt_not_taken got=%b%b exp=10", branch, taken); end
    br_cond = 2'b00;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL always_taken got=%b exp=1", taken); end
    tick(); clr_inputs();
    // cycle 7: compare 7,7 with EQ branch -> old Z=0 used
    pc_in = 9'h052; cmp_en = 1'b1; cmp_a = 8'd7; cmp_b = 8'd7;
    is_branch = 1'b1; br_cond = 2'b01;
    #1;
    checks++; if ({branch, taken} !== 2'b10) begin errors++; $display("FAIL simul_cmp_branch got=%b%b exp=10", branch, taken); end
    tick(); clr_inputs();
    // cycle 8: EQ sees Z=1 now; req_valid ignored in RUN
    pc_in = 9'h053; is_branch = 1'b1; br_cond = 2'b01;
    host.req_valid = 1'b1; host.req_addr = 9'h1FF;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL z_after_edge got=%b exp=1", taken); end
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL run_req_ready got=%b exp=0", host.req_ready); end
    tick(); clr_inputs();
    // cycle 9
    pc_in = 9'h054;
    #1;
    checks++; if (instr_cnt !== 16'd8) begin errors++; $display("FAIL run_cnt_mid got=%0d exp=8", instr_cnt); end
    tick();
  endtask

  // RUN cycle 10: halt together with a branch.
  task automatic test_halt();
    pc_in = 9'h060; is_halt = 1'b1; is_branch = 1'b1; br_cond = 2'b00;
    #1;
    checks++; if ({branch, taken} !== 2'b00) begin errors++; $display("FAIL halt_branch got=%b%b exp=00", branch, taken); end
    checks++; if (start !== 1'b1 || start_addr !== 9'h060) begin errors++; $display("FAIL halt_start got=%b/%h exp=1/060", start, start_addr); end
    checks++; if (host.done !== 1'b0) begin errors++; $display("FAIL halt_early_done got=%b exp=0", host.done); end
    tick(); clr_inputs();
    #1;
    checks++; if (host.done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", host.done); end
    checks++; if (instr_cnt !== 16'd10) begin errors++; $display("FAIL halt_cnt got=%0d exp=10", instr_cnt); end
    checks++; if (start !== 1'b1 || start_addr !== 9'h060 || host.req_ready !== 1'b0) begin errors++; $display("FAIL done_outs got=%b/%h/%b exp=1/060/0", start, start_addr, host.req_ready); end
    tick();
    #1;
    checks++; if (host.done !== 1'b0 || host.req_ready !== 1'b1) begin errors++; $display("FAIL idle_after got=%b/%b exp=0/1", host.done, host.req_ready); end
    checks++; if (start !== 1'b1 || start_addr !== 9'h060) begin errors++; $display("FAIL idle_hold_pc got=%b/%h exp=1/060", start, start_addr); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout got=%b exp=0", timeout); end
  endtask

  // Program loops on "branch always, offset 0" at pc 0x010.
  task automatic test_watchdog();
    launch(9'h010);
    tick();
`ifdef BRANCH_CTRL_WDT_EN
    for (int k = 1; k <= 20; k++) begin
      pc_in = 9'h010; is_branch = 1'b1; br_cond = 2'b00; br_offset = 8'h00;
      #1;
      checks++; if (start !== (k == 20)) begin errors++; $display("FAIL wdt_start_c%0d got=%b exp=%b", k, start, (k == 20)); end
      tick();
    end
    clr_inputs();
    #1;
    checks++; if (host.done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL wdt_done got=%b/%b exp=1/1", host.done, timeout); end
    checks++; if (instr_cnt !== 16'd20 || start_addr !== 9'h010) begin errors++; $display("FAIL wdt_cnt got=%0d/%h exp=20/010", instr_cnt, start_addr); end
    tick();
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wdt_hold got=%b exp=1", timeout); end
`else
    for (int k = 1; k <= 25; k++) begin
      pc_in = 9'h010; is_branch = 1'b1; br_cond = 2'b00; br_offset = 8'h00;
      #1;
      checks++; if (start !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL nowdt_run_c%0d got=%b/%b exp=0/0", k, start, timeout); end
      tick();
    end
    clr_inputs();
    pc_in = 9'h011; is_halt = 1'b1;
    tick(); clr_inputs();
    #1;
    checks++; if (host.done !== 1'b1 || instr_cnt !== 16'd26) begin errors++; $display("FAIL nowdt_done got=%b/%0d exp=1/26", host.done, instr_cnt); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_run();
    launch(9'h020);
    #1;
    checks++; if (timeout !== 1'b0 || instr_cnt !== 16'd0) begin errors++; $display("FAIL relaunch_clear got=%b/%0d exp=0/0", timeout, instr_cnt); end
    tick();
    for (int k = 0; k < 3; k++) begin
      pc_in = 9'h020 + 9'(k); is_branch = 1'b1; br_cond = 2'b00;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (start !== 1'b1 || start_addr !== 9'h000) begin errors++; $display("FAIL rst_run_start got=%b/%h exp=1/000", start, start_addr); end
    checks++; if (host.done !== 1'b0 || branch !== 1'b0 || host.req_ready !== 1'b1) begin errors++; $display("FAIL rst_run_outs got=%b/%b/%b exp=0/0/1", host.done, branch, host.req_ready); end
    checks++; if (instr_cnt !== 16'd0) begin errors++; $display("FAIL rst_run_cnt got=%0d exp=0", instr_cnt); end
    clr_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if (host.done !== 1'b0 || host.req_ready !== 1'b1) begin errors++; $display("FAIL rst_no_done got=%b/%b exp=0/1", host.done, host.req_ready); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branches();
    test_halt();
    tick();
    test_watchdog();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-side driver of the program counter: produces start, start_addr, branch, taken and target for prog_counter.
- Owns the program launch handshake with the host/testbench.
- Holds compare flags set by compare instructions and evaluates branch conditions.
- Detects halt and reports completion.
- Sits between the instruction decoder/ALU and prog_counter in the single-cycle core.

Parameters:
- instr_width, 9, PC/address width
- reg_width, 8, data and branch-offset width
- CNT_WIDTH, 16, width of the executed-instruction counter
- WDT_CYCLES, 1023, RUN-cycle limit (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host requests program launch
- req_addr  in  instr_width  program start address
- req_ready  out  1  block accepts a launch request
- done  out  1  one-cycle pulse when the program finishes
- pc_in  in  instr_width  current PC from prog_counter
- is_branch  in  1  decoded instruction is a branch
- br_cond  in  2  00 always, 01 EQ, 10 NE, 11 LT
- br_offset  in  reg_width  signed PC-relative offset
- cmp_en  in  1  decoded instruction is a compare
- cmp_a  in  reg_width  signed compare operand A
- cmp_b  in  reg_width  signed compare operand B
- is_halt  in  1  decoded instruction is halt
- start  out  1  to prog_counter: load start_addr
- start_addr  out  instr_width  to prog_counter
- branch  out  1  to prog_counter
- taken  out  1  to prog_counter
- target  out  reg_width  to prog_counter: signed offset
- instr_cnt  out  CNT_WIDTH  instructions executed in the current/last run
- timeout  out  1  set when the watchdog ended the run (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - addr_q=0, Z=0, N=0, instr_cnt=0, done=0, timeout=0.
  - Outputs: start=1, start_addr=0, branch=0, taken=0, req_ready=1.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - req_ready=1, start=1, start_addr=addr_q; PC is held.
  - On req_valid: latch addr_q<=req_addr, clear Z, N, instr_cnt and timeout, go to LOAD.
- LOAD (1 cycle):
  - req_ready=0, start=1, start_addr=addr_q; PC loads the program address.
  - Go to RUN.
- RUN:
  - req_ready=0; req_valid is ignored.
  - start=0 unless is_halt=1. On halt: start=1, start_addr=pc_in (freezes PC on the halt instruction), addr_q<=pc_in, go to DONE.
  - branch = is_branch & ~is_halt.
  - cond_true: always=1, EQ=Z, NE=~Z, LT=N.
  - taken = branch & cond_true.
  - target = br_offset (passed through combinationally).
  - instr_cnt increments once per RUN cycle, including the halt cycle; saturates at all-ones.
- DONE (1 cycle):
  - done=1, start=1, start_addr=addr_q, req_ready=0.
  - Go to IDLE.
- Flags:
  - On a RUN-cycle edge with cmp_en=1: Z<=(cmp_a==cmp_b), N<=($signed(cmp_a)<$signed(cmp_b)).
  - cmp_en outside RUN is ignored.
- Simultaneous cmp_en and is_branch: the branch uses the flags from before this cycle (registered); the flags update at the edge.
- is_halt together with is_branch: halt wins; branch=0, taken=0.
- Latency: branch/taken/target/start are combinational from decode inputs plus state, so prog_counter acts at the same edge.
- Reset mid-run: immediate return to IDLE with start=1 and start_addr=0; no done pulse.

Optional Feature:
- Macro: BRANCH_CTRL_WDT_EN.
- Defined:
  - A RUN-cycle counter clears on entering LOAD.
  - When it reaches WDT_CYCLES while still in RUN: timeout<=1, addr_q<=pc_in, start=1 that cycle, go to DONE (done pulses).
  - timeout holds until the next accepted request or reset.
  - is_halt in the same cycle takes priority: timeout stays 0.
- Undefined: no watchdog logic; timeout is tied to 0; RUN lasts until is_halt.

Test Plan:
- Reset release, req_valid=1 with req_addr=9'h040:
  - req_ready drops the next cycle.
  - start=1 with start_addr=0x040 in LOAD.
  - pc_in=0x040 on the first RUN cycle.
- In RUN, cmp_en with a=5, b=5, next cycle is_branch with br_cond=01 and br_offset=-3 at pc 0x045:
  - branch=1, taken=1, target=8'hFD; PC becomes 0x042.
- cmp_en with a=-2, b=1, then a branch with br_cond=10 at pc 0x050:
  - Z=0 and N=1; taken=1.
  - Re-run with br_cond=11, flags Z=0/N=0: taken=0, branch=1, PC goes 0x050->0x052.
- Simultaneous cmp_en (a=b) and an EQ branch with Z previously 0:
  - taken=0, and Z=1 after the edge.
- is_halt at pc 0x060 after 10 RUN cycles:
  - start=1 with start_addr=0x060 that cycle.
  - done pulses 1 cycle; instr_cnt=10.
  - IDLE holds the PC at 0x060; req_ready=1.
- With BRANCH_CTRL_WDT_EN and WDT_CYCLES=20, program looping on "branch always offset 0" with no halt:
  - timeout=1 and done pulses; RUN lasts 20 cycles.
  - Assert rst_n=0 mid-RUN in a second run: start=1, start_addr=0, no done.
